serial_pattern_gen: RTL and testbench
=====================================

// Module: serial_pattern_gen
// PURPOSE
//   Upstream stimulus stage for the sequence-detector Moore FSMs.
//   Loads a WIDTH-bit pattern on a start request.
//   Shifts the pattern out MSB-first on the single-bit serial line w, one bit per Clock.
//   Drives the detector's w input directly from a register, so w changes only just after posedge Clock.
//   Start/busy/done handshake lets a controller chain patterns with a one-cycle gap.
// PARAMETERS
//   WIDTH       8     pattern length in bits; legal range 2..32
//   IDLE_LEVEL  1'b0  level driven on w while not shifting
// PORTS
//   Clock      in   1                  single clock, all state updates on posedge
//   Resetn     in   1                  synchronous reset, active-low
//   start      in   1                  request: load pattern and begin shifting
//   pattern    in   WIDTH              bits to serialise, MSB sent first
//   hold       in   1                  freeze shifting while 1
//   w          out  1                  serial output bit (registered)
//   busy       out  1                  1 while a pattern bit is on w
//   done       out  1                  one-cycle pulse after the last bit
//   remaining  out  $clog2(WIDTH)      bits still to send after the current one
// BEHAVIOUR
//   Reset: a posedge with Resetn=0 has priority over all inputs.
//     - state=IDLE, shreg=0, remaining=0
//     - w=IDLE_LEVEL, busy=0, done=0
//   States: IDLE, SHIFT, DONE. All outputs are registered.
//   IDLE, start=0: hold all outputs (w=IDLE_LEVEL, busy=0, done=0).
//   IDLE, start=1: at the sampling posedge, all of the following update:
//     - shreg<=pattern
//     - w<=pattern[WIDTH-1]
//     - remaining<=WIDTH-1
//     - busy<=1, state->SHIFT
//   SHIFT, hold=0, remaining!=0:
//     - w<=next bit (MSB-first order)
//     - remaining<=remaining-1
//   SHIFT, hold=0, remaining==0:
//     - w<=IDLE_LEVEL, busy<=0, done<=1, state->DONE
//   SHIFT, hold=1: shreg, w, remaining and busy all frozen.
//     - The current bit is stretched by one cycle per held posedge.
//   DONE: lasts exactly one cycle (done=1), then done<=0.
//     - start=1 in DONE: behaves as start in IDLE (new load, state->SHIFT).
//       This gives back-to-back patterns separated by one IDLE_LEVEL cycle.
//     - start=0 in DONE: state->IDLE.
//   Latency: bit k (k=0 is the MSB) is on w from posedge start+k to start+k+1, when hold=0.
//     - busy is high for exactly WIDTH cycles plus the held cycles.
//     - done is high in cycle WIDTH (+ held cycles) after the start edge.
//   start while in SHIFT is ignored; pattern is not sampled.
//   pattern is sampled only at the accepting edge; later changes have no effect.
//   hold has no effect in IDLE or DONE.
//   Reset mid-SHIFT:
//     - the pattern is abandoned and no done pulse is issued
//     - outputs return to reset values at that edge
// TESTING
//   1 Resetn=0 for 2 cycles with start=1, pattern=8'hFF
//       -> w=0, busy=0, done=0, remaining=0 throughout.
//   2 pattern=8'b0111_0101, start for 1 cycle
//       -> w=0,1,1,1,0,1,0,1 on 8 consecutive cycles; busy=1 for 8 cycles;
//          remaining=7..0; done=1 in cycle 9 only.
//   3 As 2, with hold=1 for 3 cycles while bit 2 is on w
//       -> bit 2 (=1) lasts 4 cycles; busy lasts 11 cycles; sequence otherwise unchanged.
//   4 start=1, pattern=8'h0F issued during cycle 3 of a shift of 8'hA5
//       -> ignored; w completes 1,0,1,0,0,1,0,1.
//   5 start=1 with pattern=8'hC3 in the DONE cycle
//       -> w=IDLE_LEVEL for that one cycle, then 1,1,0,0,0,0,1,1; second done pulse follows.
//   6 Resetn=0 for one edge while bit 4 is on w
//       -> next cycle w=0, busy=0, no done pulse;
//          w stays idle until a new start.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serialises a WIDTH-bit pattern MSB-first onto w, one bit per Clock,
// with a start/busy/done handshake and a hold input that stretches the current bit.
module serial_pattern_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    input  logic                     start,
    input  logic [WIDTH-1:0]         pattern,
    input  logic                     hold,
    output logic                     w,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] remaining
);

    localparam int unsigned RW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;
    logic [RW-1:0]   remaining_n;
    logic            w_n;
    logic            busy_n;
    logic            done_n;

    // State and output registers; synchronous reset wins over every other input
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= S_IDLE;
            shreg     <= '0;
            remaining <= '0;
            w         <= IDLE_LEVEL;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            remaining <= remaining_n;
            w         <= w_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output logic; shreg rotates so the bit to send next sits at WIDTH-2
    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        remaining_n = remaining;
        w_n         = w;
        busy_n      = busy;
        done_n      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                w_n     = IDLE_LEVEL;
                busy_n  = 1'b0;
                if (start) begin
                    shreg_n     = pattern;
                    w_n         = pattern[WIDTH-1];
                    remaining_n = RW'(WIDTH - 1);
                    busy_n      = 1'b1;
                    state_n     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!hold) begin
                    if (remaining != '0) begin
                        shreg_n     = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
                        w_n         = shreg[WIDTH-2];
                        remaining_n = remaining - RW'(1);
                    end else begin
                        w_n     = IDLE_LEVEL;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: an index-based behavioural model checked every cycle,
// plus directed scenarios whose captured waveforms are compared to hand-computed literals.
module tb_serial_pattern_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned RW    = $clog2(WIDTH);
    localparam logic        IDLE  = 1'b0;

    logic             Clock;
    logic             Resetn;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic             hold;
    logic             w;
    logic             busy;
    logic             done;
    logic [RW-1:0]    remaining;

    int checks   = 0;
    int failures = 0;

    serial_pattern_gen #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .start     (start),
        .pattern   (pattern),
        .hold      (hold),
        .w         (w),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a job is a pattern plus the index of the bit currently on w
    bit               m_active = 1'b0;
    bit               m_done   = 1'b0;
    int               m_idx    = 0;
    logic [WIDTH-1:0] m_pat    = '0;

    always @(posedge Clock) begin
        if (!Resetn) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (m_active) begin
            if (!hold) begin
                if (m_idx == int'(WIDTH) - 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_pat    = pattern;
                m_idx    = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge Clock) begin
        logic          e_w;
        logic [RW-1:0] e_rem;
        e_w   = m_active ? m_pat[int'(WIDTH) - 1 - m_idx] : IDLE;
        e_rem = m_active ? RW'(int'(WIDTH) - 1 - m_idx) : '0;
        chk("model_w", 32'(w), 32'(e_w));
        chk("model_busy", 32'(busy), 32'(m_active));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_remaining", 32'(remaining), 32'(e_rem));
    end

    // Directed stimulus tables: entry i is applied before posedge i, outputs recorded after it
    localparam int N = 24;
    logic             st_start [N];
    logic             st_hold  [N];
    logic             st_rst   [N];
    logic [WIDTH-1:0] st_pat   [N];
    logic             cw [N];
    logic             cb [N];
    logic             cd [N];
    logic [RW-1:0]    cr [N];

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            st_start[i] = 1'b0;
            st_hold[i]  = 1'b0;
            st_rst[i]   = 1'b1;
            st_pat[i]   = '0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            start   = st_start[i];
            hold    = st_hold[i];
            Resetn  = st_rst[i];
            pattern = st_pat[i];
            @(negedge Clock);
            cw[i] = w;
            cb[i] = busy;
            cd[i] = done;
            cr[i] = remaining;
        end
        start  = 1'b0;
        hold   = 1'b0;
        Resetn = 1'b1;
    endtask

    function automatic int count_ones(input int which, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            if (which == 0 && cb[i] === 1'b1) c++;
            if (which == 1 && cd[i] === 1'b1) c++;
            if (which == 2 && cw[i] === 1'b1) c++;
        end
        return c;
    endfunction

    function automatic logic [31:0] pack_w(input int lo, input int hi);
        logic [31:0] v = '0;
        for (int i = lo; i <= hi; i++) v = {v[30:0], cw[i]};
        return v;
    endfunction

    initial begin
        Resetn  = 1'b0;
        start   = 1'b1;
        pattern = 8'hFF;
        hold    = 1'b0;

        // Reset held two edges with start asserted
        clear_stim();
        st_rst[0] = 1'b0; st_rst[1] = 1'b0;
        st_start[0] = 1'b1; st_start[1] = 1'b1;
        st_pat[0] = 8'hFF; st_pat[1] = 8'hFF;
        run(2);
        for (int i = 0; i < 2; i++)
            chk("reset_outputs", {29'b0, cw[i], cb[i], cd[i]} | 32'(cr[i]), 32'h0);
        clear_stim();
        run(2);

        // Plain 8-bit pattern
        clear_stim();
        st_start[0] = 1'b1; st_pat[0] = 8'b0111_0101;
        run(10);
        chk("t2_w_seq", pack_w(0, 7), 32'h75);
        chk("t2_busy_cycles", 32'(count_ones(0, 0, 9)), 32'd8);
        chk("t2_done_cycle8", 32'(cd[8]), 32'd1);
        chk("t2_done_count", 32'(count_ones(1, 0, 9)), 32'd1);
        chk("t2_rem_first", 32'(cr[0]), 32'd7);
        chk("t2_rem_last", 32'(cr[7]), 32'd0);
        chk("t2_idle_after", 32'({cw[9], cb[9], cd[9]}), 32'd0);

        // Hold for three edges while bit 2 is on w
        clear_stim();
        st_start[0] = 1'b1; st_pat[0] = 8'b0111_0101;
        st_hold[3] = 1'b1; st_hold[4] = 1'b1; st_hold[5] = 1'b1;
        run(13);
        chk("t3_w_seq", pack_w(0, 11), 32'h7EA);
        chk("t3_busy_cycles", 32'(count_ones(0, 0, 12)), 32'd11);
        chk("t3_done_cycle11", 32'(cd[11]), 32'd1);
        chk("t3_rem_held", 32'(cr[5]), 32'd5);

        // Start during a shift is ignored
        clear_stim();
        st_start[0] = 1'b1; st_pat[0] = 8'hA5;
        st_start[3] = 1'b1; st_pat[3] = 8'h0F;
        run(10);
        chk("t4_w_seq", pack_w(0, 7), 32'hA5);
        chk("t4_done_cycle8", 32'(cd[8]), 32'd1);
        chk("t4_no_restart", 32'(cb[9]), 32'd0);

        // Back-to-back patterns via start in the DONE cycle
        clear_stim();
        st_start[0] = 1'b1; st_pat[0] = 8'h81;
        st_start[9] = 1'b1; st_pat[9] = 8'hC3;
        run(19);
        chk("t5_first_seq", pack_w(0, 7), 32'h81);
        chk("t5_gap_w", 32'({cw[8], cb[8], cd[8]}), 32'b001);
        chk("t5_second_seq", pack_w(9, 16), 32'hC3);
        chk("t5_done_count", 32'(count_ones(1, 0, 18)), 32'd2);
        chk("t5_done_cycle17", 32'(cd[17]), 32'd1);

        // Reset while bit 4 is on w; hold at the start edge has no effect in IDLE
        clear_stim();
        st_start[0] = 1'b1; st_hold[0] = 1'b1; st_pat[0] = 8'hFF;
        st_rst[5] = 1'b0;
        run(16);
        chk("t6_before_w", 32'({cw[4], cb[4]}), 32'b11);
        chk("t6_before_rem", 32'(cr[4]), 32'd3);
        chk("t6_after_reset", {29'b0, cw[5], cb[5], cd[5]} | 32'(cr[5]), 32'h0);
        chk("t6_no_done", 32'(count_ones(1, 0, 15)), 32'd0);
        chk("t6_stays_idle", 32'(count_ones(2, 5, 15)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
